riscv_data_mem_ctrl: RTL
========================

// Module: riscv_data_mem_ctrl
// PURPOSE
//   Word-organised data memory with a request/ready handshake, placed directly downstream of the
//   load/store unit's memory port. Accepts one access at a time and applies byte enables on writes.
//   Returns the full 32-bit word on reads; the LSU performs lane selection and extension.
//   Adds configurable wait states so the core stall path is exercised at any latency.
// PARAMETERS
//   DEPTH_WORDS  1024  number of 32-bit words; power of two, >= 4
//   WAIT_STATES  0     extra BUSY cycles before the access executes; range 0..15
// PORTS
//   clk_i    in   1   clock, all state updates on rising edge
//   rst_ni   in   1   synchronous reset, active-low
//   req_i    in   1   access request; held high by requester until ready_o seen
//   we_i     in   1   1 = write, 0 = read; sampled with req_i in IDLE
//   be_i     in   4   byte enables, bit n -> wd_i[8n+7:8n]; writes only
//   addr_i   in   32  byte address; word index = addr_i[31:2], addr_i[1:0] ignored
//   wd_i     in   32  write data, already lane-replicated by the requester
//   rd_o     out  32  read data; valid in the ready_o cycle, held until next read completes
//   ready_o  out  1   one-cycle completion pulse
//   err_o    out  1   out-of-range flag; valid only when ready_o=1
// BEHAVIOUR
//   - Reset (rst_ni=0 at edge): state<=IDLE, ready_o=0, err_o=0, rd_o=0, wait counter=0.
//     Array contents are not reset. Reset mid-access abandons it: no pending write is performed.
//   - FSM states: IDLE, BUSY, RESP. ready_o and err_o are registered: ready_o=1 iff state==RESP.
//   - IDLE: if req_i=1, latch we_i, be_i, addr_i and wd_i. Load cnt=WAIT_STATES, go to BUSY.
//     If req_i=0, remain in IDLE.
//   - BUSY: if cnt!=0, decrement cnt and stay. If cnt==0, execute the access and go to RESP.
//     Execute means: write only the bytes whose latched be bit is 1, or read the word into rd_q.
//   - RESP: ready_o=1 and rd_o=rd_q. Go to IDLE unconditionally.
//   - req_i is ignored in BUSY and RESP. The requester still holds req_i high in the RESP cycle;
//     that must not start a second access. A new request is sampled only in IDLE.
//   - Latency: req_i first seen in IDLE at edge N -> ready_o high during cycle N+2+WAIT_STATES.
//     Minimum is 2 cycles, so ready never coincides with the first cycle of a request.
//     Back-to-back throughput is one access per 3+WAIT_STATES cycles.
//   - Out of range: latched addr[31:2] >= DEPTH_WORDS.
//     Array is not written; a read returns rd_o=0; err_o=1 in the RESP cycle. Timing is unchanged.
//   - In-range access: err_o=0. Writes leave rd_o unchanged.
//   - Write with be=4'b0000: completes normally with ready_o, and memory is unchanged.
//   - Latched inputs are frozen in BUSY/RESP. Changes on addr_i, wd_i, be_i or we_i do not
//     affect the in-flight access.
//   - Read-after-write to the same word, as back-to-back accesses, returns the new data.
// TESTING
//   1 Reset: rst_ni=0 for 2 cycles with req_i=1 -> ready_o=0, err_o=0, rd_o=0.
//     After release the FSM is in IDLE.
//   2 WAIT_STATES=0: write addr=0x10, be=F, wd=0xDEADBEEF, req at edge N -> ready_o only in N+2.
//     Then read 0x10 -> rd_o=0xDEADBEEF in its ready cycle, err_o=0.
//   3 Byte enables: write 0x11223344 to 0x20, then be=4'b0100 wd=0xAAAAAAAA.
//     Read 0x22 -> rd_o=0x11AA3344 (addr_i[1:0] ignored).
//   4 WAIT_STATES=3: read with req_i held high throughout -> ready_o exactly once, at N+5.
//     Also check addr_i changing during BUSY has no effect.
//   5 Out of range, DEPTH_WORDS=1024: write 0x1000 then read 0x1000 -> err_o=1 with each ready.
//     rd_o=0; word 0 unchanged.
//   6 Reset mid-op: write req to 0x30, WAIT_STATES=3, rst_ni=0 during BUSY.
//     Then read 0x30 -> prior contents unchanged and ready_o never pulsed for the aborted access.

Source files
------------

// File: rtl/riscv_data_mem_ctrl.sv
// riscv_data_mem_ctrl: word-organised data memory behind a req/ready handshake with byte-enabled writes and configurable wait states
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset (array contents are kept)
//   req_i   : access request, held until ready_o
//   we_i    : 1 = write, 0 = read
//   be_i    : byte enables for writes, bit n -> wd_i[8n+7:8n]
//   addr_i  : byte address, word index = addr_i[31:2]
//   wd_i    : write data, already lane-replicated
//   rd_o    : read word, held until the next read completes
//   ready_o : one-cycle completion pulse
//   err_o   : out-of-range flag, meaningful while ready_o=1
module riscv_data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o,
    output logic        ready_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        start, exec, oor;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH_WORDS];
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^addr_i[1:0];
    always_comb begin
        start   = state_q == IDLE && req_i;
        // the access executes on the edge that leaves BUSY, so RESP always follows it
        exec    = state_q == BUSY && cnt_q == 4'd0;
        oor     = addr_q >= 30'(DEPTH_WORDS);
        idx     = addr_q[AW-1:0];
        state_d = start ? BUSY : exec ? RESP : state_q == RESP ? IDLE : state_q;
        cnt_d   = start ? 4'(WAIT_STATES) : (state_q == BUSY && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        we_d    = start ? we_i : we_q;
        be_d    = start ? be_i : be_q;
        addr_d  = start ? addr_i[31:2] : addr_q;
        wd_d    = start ? wd_i : wd_q;
        rd_d    = (exec && !we_q) ? (oor ? 32'h0 : mem[idx]) : rd_q;
        ready_d = exec;
        err_d   = exec && oor;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
        we_q   <= we_d;
        be_q   <= be_d;
        addr_q <= addr_d;
        wd_q   <= wd_d;
    end
    // gating on rst_ni drops a write that would execute on the reset edge
    always_ff @(posedge clk_i) begin
        if (rst_ni && exec && we_q && !oor)
            for (int b = 0; b < 4; b++)
                if (be_q[b]) mem[idx][8*b +: 8] <= wd_q[8*b +: 8];
    end
    assign rd_o    = rd_q;
    assign ready_o = ready_q;
    assign err_o   = err_q;
endmodule
